// File: rtl/top_datapath.sv
// rtl/top_datapath.sv - flat-bus datapath: sliced operands, parallel registered units, packed result bus
module top_datapath #(
  parameter int          IN_W      = 277,
  parameter int          OUT_W     = 330,
  parameter logic [31:0] LFSR_SEED = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_flat,
  output logic [OUT_W-1:0] out_flat
);

  // Input field slices
  logic [31:0] a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w;
  logic [3:0]  op_w;
  logic        en_w, clr_w;
  logic [4:0]  sh_w;
  logic [1:0]  sel_w;
  logic [7:0]  mask8_w;

  assign a_w     = in_flat[31:0];
  assign b_w     = in_flat[63:32];
  assign c_w     = in_flat[95:64];
  assign d_w     = in_flat[127:96];
  assign e_w     = in_flat[159:128];
  assign f_w     = in_flat[191:160];
  assign g_w     = in_flat[223:192];
  assign h_w     = in_flat[255:224];
  assign op_w    = in_flat[259:256];
  assign en_w    = in_flat[260];
  assign clr_w   = in_flat[261];
  assign sh_w    = in_flat[266:262];
  assign sel_w   = in_flat[268:267];
  assign mask8_w = in_flat[276:269];

  // Registered state and next-state values
  logic [63:0] prod_q,  prod_d;
  logic [32:0] sum_q,   sum_d;
  logic [31:0] alu_q,   alu_d;
  logic [31:0] acc_q,   acc_d;
  logic [31:0] rot_q,   rot_d;
  logic [31:0] lfsr_q,  lfsr_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [5:0]  pop_q,   pop_d;
  logic [5:0]  lzc_q,   lzc_d;
  logic [7:0]  xmask_q, xmask_d;
  logic [31:0] pipe1_q, pipe1_d;
  logic [31:0] pipe2_q;
  logic [31:0] max_q,   max_d;
  logic        zero_q,  zero_d;
  logic        eq_q,    eq_d;
  logic        ovf_q,   ovf_d;
  logic        par_q,   par_d;
  logic        valid_q;

  logic [32:0] acc_sum_w;
  logic [63:0] rot_dbl_w;

  // Wide arithmetic: full product and carry-preserving sum
  always_comb begin
    prod_d = 64'(a_w) * 64'(b_w);
    sum_d  = 33'(c_w) + 33'(d_w);
  end

  // ALU operation select on e/f, plus the zero flag taken from the same result
  always_comb begin
    alu_d = 32'd0;
    case (op_w)
      4'd0:    alu_d = e_w + f_w;
      4'd1:    alu_d = e_w - f_w;
      4'd2:    alu_d = e_w & f_w;
      4'd3:    alu_d = e_w | f_w;
      4'd4:    alu_d = e_w ^ f_w;
      4'd5:    alu_d = ~(e_w | f_w);
      4'd6:    alu_d = e_w << f_w[4:0];
      4'd7:    alu_d = e_w >> f_w[4:0];
      4'd8:    alu_d = 32'($signed(e_w) >>> f_w[4:0]);
      4'd9:    alu_d = {31'd0, ($signed(e_w) < $signed(f_w))};
      4'd10:   alu_d = {31'd0, (e_w < f_w)};
      4'd11:   alu_d = e_w * f_w;
      4'd12:   alu_d = (e_w < f_w) ? e_w : f_w;
      4'd13:   alu_d = ($signed(e_w) > $signed(f_w)) ? e_w : f_w;
      4'd14:   alu_d = e_w;
      default: alu_d = ~e_w;
    endcase
    zero_d = (alu_d == 32'd0);
  end

  // Accumulator: clear beats enable; overflow flag is sticky until clear
  always_comb begin
    acc_sum_w = 33'(acc_q) + 33'(g_w);
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (clr_w) begin
      acc_d = 32'd0;
      ovf_d = 1'b0;
    end else if (en_w) begin
      acc_d = acc_sum_w[31:0];
      if (acc_sum_w[32]) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Rotate-left by doubling the word and taking the upper half after the shift
  always_comb begin
    rot_dbl_w = {h_w, h_w} << sh_w;
    rot_d     = rot_dbl_w[63:32];
  end

  // Free-running sequence sources: LFSR steps every edge, counter starts once valid
  always_comb begin
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    cnt_d  = valid_q ? cnt_q + 16'd1 : cnt_q;
  end

  // Bit-count logic: population count of a, leading zeros of b (32 when b is zero)
  always_comb begin
    pop_d = 6'd0;
    lzc_d = 6'd32;
    for (int i = 0; i < 32; i++) begin
      pop_d = pop_d + 6'(a_w[i]);
      if (b_w[i]) begin
        lzc_d = 6'(31 - i);
      end
    end
  end

  // Byte fold of h, selector stage-1 mux, compare flags and input parity
  always_comb begin
    xmask_d = (h_w[7:0] ^ h_w[15:8] ^ h_w[23:16] ^ h_w[31:24]) & mask8_w;
    case (sel_w)
      2'd0:    pipe1_d = a_w;
      2'd1:    pipe1_d = b_w;
      2'd2:    pipe1_d = c_w;
      default: pipe1_d = d_w;
    endcase
    max_d = (e_w > f_w) ? e_w : f_w;
    eq_d  = (e_w == f_w);
    par_d = ^in_flat;
  end

  // State register for every unit; reset clears all but the LFSR, which reloads its seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      sum_q   <= '0;
      alu_q   <= '0;
      acc_q   <= '0;
      rot_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      pop_q   <= '0;
      lzc_q   <= '0;
      xmask_q <= '0;
      pipe1_q <= '0;
      pipe2_q <= '0;
      max_q   <= '0;
      zero_q  <= 1'b0;
      eq_q    <= 1'b0;
      ovf_q   <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      alu_q   <= alu_d;
      acc_q   <= acc_d;
      rot_q   <= rot_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      lzc_q   <= lzc_d;
      xmask_q <= xmask_d;
      pipe1_q <= pipe1_d;
      pipe2_q <= pipe1_q;
      max_q   <= max_d;
      zero_q  <= zero_d;
      eq_q    <= eq_d;
      ovf_q   <= ovf_d;
      par_q   <= par_d;
      valid_q <= 1'b1;
    end
  end

  assign out_flat = {valid_q, par_q, ovf_q, eq_q, zero_q, max_q, pipe2_q, xmask_q,
                     lzc_q, pop_q, cnt_q, lfsr_q, rot_q, acc_q, alu_q, sum_q, prod_q};

endmodule

// File: tb/tb_top_datapath.sv
// tb/tb_top_datapath.sv - directed scoreboard bench for top_datapath
module tb_top_datapath;

  logic         clk;
  logic         rst_n;
  logic [276:0] in_flat;
  logic [329:0] out_flat;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [3:0]  op;
  logic        en, clr;
  logic [4:0]  sh;
  logic [1:0]  sel;
  logic [7:0]  mask8;

  assign in_flat = {mask8, sel, sh, clr, en, op, h, g, f, e, d, c, b, a};

  top_datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          msb;
    int          lsb;
    logic [63:0] exp;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cycle;
  int          vectors;
  int          miscompares;
  logic [329:0] rst_val;
  logic [31:0]  lfsr_m;

  function automatic logic [63:0] field(input int msb, input int lsb);
    logic [329:0] t;
    int           w;
    t = out_flat >> lsb;
    w = msb - lsb + 1;
    return t[63:0] & ((w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic push(input string tag, input int msb, input int lsb,
                      input logic [63:0] exp, input int lat);
    exp_t it;
    it.tag = tag; it.msb = msb; it.lsb = lsb; it.exp = exp; it.due = cycle + lat;
    sb.push_back(it);
  endtask

  task automatic check_due();
    int          i;
    logic [63:0] obs;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cycle) begin
        obs = field(sb[i].msb, sb[i].lsb);
        vectors++;
        assert (obs === sb[i].exp) else begin
          miscompares++;
          $error("FAIL %s: observed %h expected %h (cycle %0d)", sb[i].tag, obs, sb[i].exp, cycle);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    lfsr_m = lfsr_step(lfsr_m);
    check_due();
  endtask

  task automatic check_reset(input string tag);
    vectors++;
    assert (out_flat === rst_val) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, out_flat, rst_val);
    end
  endtask

  task automatic alu_step(input logic [3:0] o, input logic [31:0] exp, input string tag);
    op = o;
    push(tag, 128, 97, 64'(exp), 1);
    push({tag, "_zero"}, 325, 325, 64'(exp == 32'd0), 1);
    tick();
  endtask

  initial begin
    cycle = 0; vectors = 0; miscompares = 0;
    rst_val = 330'(32'hFFFF_FFFF) << 193;
    {a, b, c, d, e, f, g, h} = '0;
    op = '0; en = 1'b0; clr = 1'b0; sh = '0; sel = '0; mask8 = '0;

    // Reset held: everything zero except the LFSR seed
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");

    // Release away from the edge; first edge gives valid, cnt 0, first LFSR step
    @(negedge clk);
    rst_n  = 1'b1;
    lfsr_m = 32'hFFFF_FFFF;
    cycle  = 0;
    push("valid_first", 329, 329, 64'd1, 1);
    push("cnt_first", 240, 225, 64'd0, 1);
    push("lfsr_first", 224, 193, 64'hFFFF_FFFE, 1);
    tick();
    push("cnt_second", 240, 225, 64'd1, 1);
    push("lfsr_second", 224, 193, 64'(lfsr_step(lfsr_m)), 1);
    tick();

    // Arithmetic corners
    a = 32'hFFFF_FFFF; b = 32'd2; c = 32'hFFFF_FFFF; d = 32'hFFFF_FFFF;
    #1;
    push("prod", 63, 0, 64'h1_FFFF_FFFE, 1);
    push("sum", 96, 64, 64'h1_FFFF_FFFE, 1);
    push("popcount", 246, 241, 64'd32, 1);
    push("lzc", 252, 247, 64'd30, 1);
    push("parity", 328, 328, 64'(^in_flat), 1);
    tick();
    b = 32'd0;
    push("lzc_zero", 252, 247, 64'd32, 1);
    tick();

    // ALU sweep with e=80000000, f=1
    e = 32'h8000_0000; f = 32'h0000_0001;
    push("max_ef", 324, 293, 64'h8000_0000, 1);
    push("eq_ef", 326, 326, 64'd0, 1);
    alu_step(4'd8,  32'hC000_0000, "alu_sra");
    alu_step(4'd9,  32'd1,         "alu_slt");
    alu_step(4'd10, 32'd0,         "alu_sltu");
    alu_step(4'd1,  32'h7FFF_FFFF, "alu_sub");
    alu_step(4'd2,  32'd0,         "alu_and");
    alu_step(4'd0,  32'h8000_0001, "alu_add");
    alu_step(4'd5,  32'h7FFF_FFFE, "alu_nor");
    alu_step(4'd12, 32'd1,         "alu_minu");
    alu_step(4'd13, 32'd1,         "alu_maxs");
    alu_step(4'd15, 32'h7FFF_FFFF, "alu_not");
    f = 32'h8000_0000;
    push("eq_same", 326, 326, 64'd1, 1);
    tick();

    // Accumulator wrap, sticky overflow, hold, clear-over-enable
    en = 1'b1; g = 32'hFFFF_FFFF;
    push("acc_1", 160, 129, 64'hFFFF_FFFF, 1);
    push("ovf_1", 327, 327, 64'd0, 1);
    tick();
    push("acc_2", 160, 129, 64'hFFFF_FFFE, 1);
    push("ovf_2", 327, 327, 64'd1, 1);
    tick();
    en = 1'b0;
    push("acc_hold", 160, 129, 64'hFFFF_FFFE, 1);
    push("ovf_hold", 327, 327, 64'd1, 1);
    tick();
    en = 1'b1; clr = 1'b1;
    push("acc_clr", 160, 129, 64'd0, 1);
    push("ovf_clr", 327, 327, 64'd0, 1);
    tick();
    en = 1'b0; clr = 1'b0;

    // Selector pipeline (2 cycles), rotate, byte fold
    sel = 2'd2; c = 32'h1234_5678; h = 32'h8000_0001; sh = 5'd1; mask8 = 8'hFF;
    push("pipe_c", 292, 261, 64'h1234_5678, 2);
    push("rot", 192, 161, 64'h0000_0003, 1);
    push("xmask_ff", 260, 253, 64'h81, 1);
    tick();
    sel = 2'd0; a = 32'hA5A5_A5A5; sh = 5'd0; mask8 = 8'h0F;
    push("pipe_a", 292, 261, 64'hA5A5_A5A5, 2);
    push("rot_zero", 192, 161, 64'h8000_0001, 1);
    push("xmask_0f", 260, 253, 64'h01, 1);
    tick();
    sel = 2'd3; d = 32'hDEAD_BEEF; h = 32'h1234_5678; sh = 5'd31;
    push("pipe_d", 292, 261, 64'hDEAD_BEEF, 2);
    push("rot_31", 192, 161, 64'h091A_2B3C, 1);
    tick();
    push("cnt_run", 240, 225, 64'(cycle), 1);
    push("lfsr_run", 224, 193, 64'(lfsr_step(lfsr_m)), 1);
    tick();
    tick();

    // Mid-run asynchronous reset: clears between edges, then restarts
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(posedge clk);
    #1;
    check_reset("reset_held_edge");
    @(negedge clk);
    rst_n  = 1'b1;
    lfsr_m = 32'hFFFF_FFFF;
    cycle  = 0;
    push("valid_restart", 329, 329, 64'd1, 1);
    push("cnt_restart", 240, 225, 64'd0, 1);
    push("lfsr_restart", 224, 193, 64'hFFFF_FFFE, 1);
    push("pipe_flushed", 292, 261, 64'd0, 1);
    tick();
    push("cnt_restart2", 240, 225, 64'd1, 1);
    tick();

    // Anything still queued never came due
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed none expected %h (never checked)", sb[0].tag, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
